// File: rtl/button_debouncer_if.sv
// ---------------------------------------------------------------------------
// button_debouncer_if
//
// Groups the button-facing signals of button_debouncer into one bundle.
//
// Signals (NBTN bits each):
//   BTN_IN      raw button pins, active-high, asynchronous to the clock
//   BTN_LEVEL   debounced level per button
//   BTN_PRESS   one-cycle pulse on an accepted 0->1
//   BTN_RELEASE one-cycle pulse on an accepted 1->0
//   BTN_LONG    one-cycle long-press pulse (constant 0 when the feature is off)
//
// Modports:
//   master  board / testbench side: drives BTN_IN, observes the outputs
//   slave   debouncer side: samples BTN_IN, drives the outputs
// ---------------------------------------------------------------------------
interface button_debouncer_if #(
    parameter int NBTN = 4
);
    logic [NBTN-1:0] BTN_IN;
    logic [NBTN-1:0] BTN_LEVEL;
    logic [NBTN-1:0] BTN_PRESS;
    logic [NBTN-1:0] BTN_RELEASE;
    logic [NBTN-1:0] BTN_LONG;

    modport master (
        output BTN_IN,
        input  BTN_LEVEL,
        input  BTN_PRESS,
        input  BTN_RELEASE,
        input  BTN_LONG
    );

    modport slave (
        input  BTN_IN,
        output BTN_LEVEL,
        output BTN_PRESS,
        output BTN_RELEASE,
        output BTN_LONG
    );
endinterface

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Brings NBTN raw board buttons into the CLK domain. Each pin goes through a
// 2-flop synchronizer, is sampled on a shared prescaled tick and is debounced
// by its own 4-state FSM (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT). A level
// change is accepted after STABLE consecutive agreeing tick samples.
//
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous, active-high; clears all state
//   bus    button_debouncer_if.slave
//            BTN_IN      raw pins (1 = pressed)
//            BTN_LEVEL   registered debounced level
//            BTN_PRESS   one-cycle pulse after the tick accepting 0->1
//            BTN_RELEASE one-cycle pulse after the tick accepting 1->0
//            BTN_LONG    one-cycle long-press pulse
//
// Parameters:
//   NBTN        number of buttons (must match the interface instance)
//   TICK_LOG2   sample tick every 2^TICK_LOG2 clocks (1..24)
//   STABLE      agreeing samples to accept a change (2..15)
//   LONG_TICKS  ticks held before the long-press pulse (1..65535)
//
// Optional feature macro: BUTTON_DEBOUNCER_LONG_PRESS_EN
//   Defined   : per-button 16-bit saturating hold counter, BTN_LONG pulses
//               once per press when the hold reaches LONG_TICKS.
//   Undefined : no hold counters, BTN_LONG tied to 0.
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int NBTN       = 4,
    parameter int TICK_LOG2  = 16,
    parameter int STABLE     = 4,
    parameter int LONG_TICKS = 256
) (
    input  logic                 CLK,
    input  logic                 RESET,
    button_debouncer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // An out-of-range configuration never produces a tick, so the block stays
    // inert instead of debouncing with a truncated threshold.
    localparam bit PARAMS_OK = (TICK_LOG2 >= 1) && (TICK_LOG2 <= 24) &&
                               (STABLE >= 2) && (STABLE <= 15) &&
                               (LONG_TICKS >= 1) && (LONG_TICKS <= 65535);

    localparam logic [3:0]           STABLE_C  = 4'(STABLE);
    localparam logic [TICK_LOG2-1:0] PRESC_ONE = TICK_LOG2'(1);

    // -----------------------------------------------------------------------
    // Two-flop synchronizer per pin
    // -----------------------------------------------------------------------
    logic [NBTN-1:0] sync1_reg;
    logic [NBTN-1:0] sync2_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= bus.BTN_IN;
            sync2_reg <= sync1_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Shared prescaler: tick is high during the cycle the counter is all-ones,
    // so the FSMs act on the edge that wraps it back to zero.
    // -----------------------------------------------------------------------
    logic [TICK_LOG2-1:0] presc_reg;
    logic                 tick;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRESC_ONE;
        end
    end

    assign tick = (&presc_reg) && PARAMS_OK;

    // -----------------------------------------------------------------------
    // Per-button debounce FSM
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            state_t     state_reg, state_next;
            logic [3:0] cnt_reg, cnt_next;
            logic       level_reg, level_next;
            logic       press_reg, press_next;
            logic       release_reg, release_next;
            logic       sample;
            logic [3:0] cnt_inc;

            assign sample  = sync2_reg[gi];
            assign cnt_inc = cnt_reg + 4'd1;

            always_comb begin
                state_next   = state_reg;
                cnt_next     = cnt_reg;
                level_next   = level_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                if (tick) begin
                    case (state_reg)
                        IDLE: begin
                            if (sample) begin
                                state_next = PRESS_WAIT;
                                cnt_next   = 4'd1;
                            end
                        end
                        PRESS_WAIT: begin
                            if (!sample) begin
                                state_next = IDLE;
                                cnt_next   = 4'd0;
                            end else if (cnt_inc == STABLE_C) begin
                                state_next = PRESSED;
                                cnt_next   = 4'd0;
                                level_next = 1'b1;
                                press_next = 1'b1;
                            end else begin
                                cnt_next = cnt_inc;
                            end
                        end
                        PRESSED: begin
                            if (!sample) begin
                                state_next = RELEASE_WAIT;
                                cnt_next   = 4'd1;
                            end
                        end
                        RELEASE_WAIT: begin
                            if (sample) begin
                                state_next = PRESSED;
                                cnt_next   = 4'd0;
                            end else if (cnt_inc == STABLE_C) begin
                                state_next   = IDLE;
                                cnt_next     = 4'd0;
                                level_next   = 1'b0;
                                release_next = 1'b1;
                            end else begin
                                cnt_next = cnt_inc;
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            cnt_next   = 4'd0;
                        end
                    endcase
                end
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    state_reg   <= IDLE;
                    cnt_reg     <= 4'd0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    state_reg   <= state_next;
                    cnt_reg     <= cnt_next;
                    level_reg   <= level_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            assign bus.BTN_LEVEL[gi]   = level_reg;
            assign bus.BTN_PRESS[gi]   = press_reg;
            assign bus.BTN_RELEASE[gi] = release_reg;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
            localparam logic [15:0] LONG_C = 16'(LONG_TICKS);

            logic [15:0] hold_reg, hold_next;
            logic [15:0] hold_inc;
            logic        long_reg, long_next;

            // Saturating so a very long hold never wraps into a second pulse.
            assign hold_inc = (hold_reg == 16'hFFFF) ? hold_reg : hold_reg + 16'd1;

            always_comb begin
                hold_next = hold_reg;
                long_next = 1'b0;
                if (tick) begin
                    if (state_reg == PRESS_WAIT && state_next == PRESSED) begin
                        hold_next = 16'd0;
                    end else if (state_reg == PRESSED || state_reg == RELEASE_WAIT) begin
                        // A rejected release keeps counting; only the exact
                        // crossing into LONG_TICKS fires, once per press.
                        hold_next = hold_inc;
                        long_next = (hold_reg != LONG_C) && (hold_inc == LONG_C);
                    end else begin
                        hold_next = 16'd0;
                    end
                end
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    hold_reg <= 16'd0;
                    long_reg <= 1'b0;
                end else begin
                    hold_reg <= hold_next;
                    long_reg <= long_next;
                end
            end

            assign bus.BTN_LONG[gi] = long_reg;
`else
            assign bus.BTN_LONG[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer with TICK_LOG2=2, STABLE=3,
// LONG_TICKS=5, NBTN=4. Edges are numbered from the reset release (E0);
// FSM sample edges are E4, E8, ... and expected values are written against
// those edge numbers.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int NBTN = 4;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    button_debouncer_if #(.NBTN(NBTN)) bus ();

    button_debouncer #(
        .NBTN       (NBTN),
        .TICK_LOG2  (2),
        .STABLE     (3),
        .LONG_TICKS (5)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    int press_n   [NBTN];
    int release_n [NBTN];
    int long_n    [NBTN];
    int overlap_n = 0;

    initial begin
        for (int i = 0; i < NBTN; i++) begin
            press_n[i]   = 0;
            release_n[i] = 0;
            long_n[i]    = 0;
        end
    end

    // Pulse counters, sampled mid-cycle.
    always @(negedge CLK) begin
        for (int i = 0; i < NBTN; i++) begin
            press_n[i]   += int'(bus.BTN_PRESS[i]);
            release_n[i] += int'(bus.BTN_RELEASE[i]);
            long_n[i]    += int'(bus.BTN_LONG[i]);
            if (bus.BTN_PRESS[i] && bus.BTN_RELEASE[i]) overlap_n++;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (E%0d)", tag, got, exp, edge_n);
        end else begin
            $display("ok   %s: %h (E%0d)", tag, got, edge_n);
        end
    endtask

    // Advance to 1 time unit after edge k.
    task automatic to_edge(input int k);
        while (edge_n < k) begin
            @(posedge CLK);
            edge_n++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.BTN_IN = 4'b0000;
        RESET      = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_level",   16'(bus.BTN_LEVEL),   16'h0);
        check("reset_press",   16'(bus.BTN_PRESS),   16'h0);
        check("reset_release", 16'(bus.BTN_RELEASE), 16'h0);
        check("reset_long",    16'(bus.BTN_LONG),    16'h0);

        // Clean press on button 0, accepted at E12.
        RESET      = 1'b0;
        edge_n     = 0;
        bus.BTN_IN = 4'b0001;
        to_edge(11);
        check("b0_press_early", 16'(bus.BTN_PRESS), 16'h0);
        check("b0_level_early", 16'(bus.BTN_LEVEL), 16'h0);
        to_edge(12);
        check("b0_press",       16'(bus.BTN_PRESS), 16'h1);
        check("b0_level",       16'(bus.BTN_LEVEL), 16'h1);
        to_edge(13);
        check("b0_press_once",  16'(bus.BTN_PRESS), 16'h0);

        // Button 1 glitch: 6 cycles high, only one tick sees it.
        to_edge(14);
        bus.BTN_IN = 4'b0011;
        to_edge(20);
        bus.BTN_IN = 4'b0001;

        // Long press on button 0: 5 ticks after E12 -> E32.
        to_edge(31);
        check("b0_long_early", 16'(bus.BTN_LONG), 16'h0);
        to_edge(32);
        check("b0_long",       16'(bus.BTN_LONG), LONG_EN ? 16'h1 : 16'h0);
        to_edge(33);
        check("b0_long_once",  16'(bus.BTN_LONG), 16'h0);
        check("b1_glitch_level", 16'(bus.BTN_LEVEL), 16'h1);
        check("b1_glitch_press", 16'(press_n[1]), 16'h0);

        // Button 2 press, accepted at E48.
        to_edge(36);
        bus.BTN_IN = 4'b0101;
        to_edge(47);
        check("b2_press_early", 16'(bus.BTN_PRESS), 16'h0);
        to_edge(48);
        check("b2_press",       16'(bus.BTN_PRESS), 16'h4);
        check("b2_level",       16'(bus.BTN_LEVEL), 16'h5);

        // Release with a one-tick bounce back to 1, final 0 from E64.
        to_edge(56);
        bus.BTN_IN = 4'b0001;
        to_edge(60);
        bus.BTN_IN = 4'b0101;
        to_edge(64);
        bus.BTN_IN = 4'b0001;
        to_edge(68);
        // Hold counter survived the rejected release: 5 ticks since E48.
        check("b2_long_thru_bounce", 16'(bus.BTN_LONG), LONG_EN ? 16'h4 : 16'h0);
        check("b2_level_bounce",     16'(bus.BTN_LEVEL), 16'h5);
        to_edge(75);
        check("b2_release_early", 16'(bus.BTN_RELEASE), 16'h0);
        check("b2_level_held",    16'(bus.BTN_LEVEL),   16'h5);
        to_edge(76);
        check("b2_release",       16'(bus.BTN_RELEASE), 16'h4);
        check("b2_level_off",     16'(bus.BTN_LEVEL),   16'h1);
        to_edge(77);
        check("b2_release_once",  16'(bus.BTN_RELEASE), 16'h0);

        // Release button 0, accepted at E92.
        to_edge(78);
        bus.BTN_IN = 4'b0000;
        to_edge(91);
        check("b0_level_before_rel", 16'(bus.BTN_LEVEL), 16'h1);
        to_edge(92);
        check("b0_release",  16'(bus.BTN_RELEASE), 16'h1);
        check("b0_level_off", 16'(bus.BTN_LEVEL),  16'h0);

        // All four together, accepted at E108.
        to_edge(96);
        bus.BTN_IN = 4'b1111;
        to_edge(107);
        check("all_press_early", 16'(bus.BTN_PRESS), 16'h0);
        to_edge(108);
        check("all_press",       16'(bus.BTN_PRESS), 16'hF);
        check("all_level",       16'(bus.BTN_LEVEL), 16'hF);
        to_edge(109);
        check("all_press_once",  16'(bus.BTN_PRESS), 16'h0);

        // Reset while held: outputs clear at once, no release pulses.
        to_edge(112);
        RESET = 1'b1;
        #1;
        check("rst_held_level", 16'(bus.BTN_LEVEL),   16'h0);
        check("rst_held_rel",   16'(bus.BTN_RELEASE), 16'h0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hold_level", 16'(bus.BTN_LEVEL), 16'h0);
        RESET  = 1'b0;
        edge_n = 0;
        to_edge(11);
        check("re_press_early", 16'(bus.BTN_PRESS), 16'h0);
        check("re_level_early", 16'(bus.BTN_LEVEL), 16'h0);
        to_edge(12);
        check("re_press",       16'(bus.BTN_PRESS), 16'hF);
        check("re_level",       16'(bus.BTN_LEVEL), 16'hF);
        to_edge(14);

        // Pulse totals over the whole run.
        check("press_n0",   16'(press_n[0]),   16'd3);
        check("press_n1",   16'(press_n[1]),   16'd2);
        check("press_n2",   16'(press_n[2]),   16'd3);
        check("press_n3",   16'(press_n[3]),   16'd2);
        check("release_n0", 16'(release_n[0]), 16'd1);
        check("release_n1", 16'(release_n[1]), 16'd0);
        check("release_n2", 16'(release_n[2]), 16'd1);
        check("release_n3", 16'(release_n[3]), 16'd0);
        check("long_n0",    16'(long_n[0]),    LONG_EN ? 16'd1 : 16'd0);
        check("long_n1",    16'(long_n[1]),    16'd0);
        check("long_n2",    16'(long_n[2]),    LONG_EN ? 16'd1 : 16'd0);
        check("long_n3",    16'(long_n[3]),    16'd0);
        check("press_release_overlap", 16'(overlap_n), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
